// File: rtl/conv_layer_scheduler_if.sv
// Handshake and address bundle between the layer sequencer, the layer
// scheduler and the conv/pool engines.
interface conv_layer_scheduler_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned NF_W   = 4
);
    logic              start;
    logic [NF_W-1:0]   num_filters;
    logic              pool_en;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] out_base;
    logic              conv_start;
    logic              conv_done;
    logic              pool_start;
    logic              pool_done;
    logic [ADDR_W-1:0] w_addr_base;
    logic [ADDR_W-1:0] out_addr_base;
    logic [NF_W-1:0]   filter_idx;
    logic              busy;
    logic              layer_done;
    logic              err;

    // Sequencer / engine side
    modport master (
        output start, num_filters, pool_en, w_base, out_base, conv_done, pool_done,
        input  conv_start, pool_start, w_addr_base, out_addr_base, filter_idx,
               busy, layer_done, err
    );

    // Scheduler side
    modport slave (
        input  start, num_filters, pool_en, w_base, out_base, conv_done, pool_done,
        output conv_start, pool_start, w_addr_base, out_addr_base, filter_idx,
               busy, layer_done, err
    );
endinterface

// File: rtl/conv_layer_scheduler.sv
// Runs the single-filter conv controller once per output filter, with an
// optional pool pass after each, and reports layer completion upward.
module conv_layer_scheduler #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned NF_W         = 4,
    parameter int unsigned KERNEL_WORDS = 9,
    parameter int unsigned FMAP_WORDS   = 676
) (
    input logic                  clk,
    input logic                  rst,
    conv_layer_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SETUP, KICK, WAIT_CONV, POOL_KICK, WAIT_POOL, NEXT, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] KW_STEP = ADDR_W'(KERNEL_WORDS);
    localparam logic [ADDR_W-1:0] FM_STEP = ADDR_W'(FMAP_WORDS);

    state_t            state, state_nx;
    logic [NF_W-1:0]   nf_q, fi_q;
    logic              pool_en_q;
    logic [ADDR_W-1:0] w_base_q, out_base_q;
    logic [ADDR_W-1:0] w_addr_q, out_addr_q;
    logic              err_q;
    logic              last_filter;
    logic              accept;
    logic              stray_done;

    assign last_filter = (fi_q == nf_q - NF_W'(1));
    assign accept      = (state == IDLE) && bus.start;
    assign stray_done  = (bus.conv_done && state != WAIT_CONV) ||
                         (bus.pool_done && state != WAIT_POOL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (bus.start) state_nx = SETUP;
            SETUP:     state_nx = (nf_q == '0) ? DONE : KICK;
            KICK:      state_nx = WAIT_CONV;
            WAIT_CONV: if (bus.conv_done) state_nx = pool_en_q ? POOL_KICK : NEXT;
            POOL_KICK: state_nx = WAIT_POOL;
            WAIT_POOL: if (bus.pool_done) state_nx = NEXT;
            NEXT:      state_nx = last_filter ? DONE : KICK;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nf_q       <= '0;
            fi_q       <= '0;
            pool_en_q  <= 1'b0;
            w_base_q   <= '0;
            out_base_q <= '0;
            w_addr_q   <= '0;
            out_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                nf_q       <= bus.num_filters;
                pool_en_q  <= bus.pool_en;
                w_base_q   <= bus.w_base;
                out_base_q <= bus.out_base;
                fi_q       <= '0;
            end
            if (state == SETUP) begin
                w_addr_q   <= w_base_q;
                out_addr_q <= out_base_q;
            end
            // Incremental per-filter stepping; sums wrap silently at ADDR_W
            if (state == NEXT && !last_filter) begin
                fi_q       <= fi_q + NF_W'(1);
                w_addr_q   <= w_addr_q + KW_STEP;
                out_addr_q <= out_addr_q + FM_STEP;
            end
            // A stray done in the accepting cycle still flags the new layer
            err_q <= (accept ? 1'b0 : err_q) | stray_done;
        end
    end

    always_comb begin
        bus.conv_start    = (state == KICK);
        bus.pool_start    = (state == POOL_KICK);
        bus.layer_done    = (state == DONE);
        bus.busy          = (state != IDLE);
        bus.w_addr_base   = w_addr_q;
        bus.out_addr_base = out_addr_q;
        bus.filter_idx    = fi_q;
        bus.err           = err_q;
    end
endmodule

// File: doc/conv_layer_scheduler.md
# conv_layer_scheduler

Sequences one convolutional layer by running the single-filter convolution controller once per output filter. For each filter it computes the weight and output-feature-map base addresses, pulses the convolution start and waits for its completion, then runs an optional pooling pass. It sits between the top-level layer sequencer and the conv/pool engines, and signals layer completion upward.

## Interface
Parameters:
- `ADDR_W`, 12, width of every address bus.
- `NF_W`, 4, width of the filter count and filter index.
- `KERNEL_WORDS`, 9, weight words per filter; added to the weight base for each filter.
- `FMAP_WORDS`, 676, output words per filter map; added to the output base for each filter.

Ports (clock and reset first):
- `clk`, in, 1, system clock, rising edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `start`, in, 1, begin a layer; sampled only in IDLE.
- `num_filters`, in, NF_W, filter count; latched on an accepted start.
- `pool_en`, in, 1, run a pool pass after each filter; latched on an accepted start.
- `w_base`, in, ADDR_W, weight base of filter 0; latched on an accepted start.
- `out_base`, in, ADDR_W, output base of filter 0; latched on an accepted start.
- `conv_start`, out, 1, one-cycle start pulse to the conv controller.
- `conv_done`, in, 1, one-cycle completion pulse from the conv controller.
- `pool_start`, out, 1, one-cycle start pulse to the pool engine.
- `pool_done`, in, 1, one-cycle completion pulse from the pool engine.
- `w_addr_base`, out, ADDR_W, weight base address of the current filter.
- `out_addr_base`, out, ADDR_W, output base address of the current filter.
- `filter_idx`, out, NF_W, index of the current filter.
- `busy`, out, 1, high in every state except IDLE.
- `layer_done`, out, 1, one-cycle pulse when the layer finishes.
- `err`, out, 1, sticky protocol-error flag.

## Operation
- All outputs are registered or decoded from the state register (Moore).
- Reset value of every output is 0; the state resets to IDLE.

State machine:
- **IDLE**: when `start`=1, latch the inputs, clear `filter_idx` and `err`, and go to SETUP.
- **SETUP**: load `w_addr_base`=`w_base` and `out_addr_base`=`out_base`. If the latched `num_filters`=0, go to DONE; otherwise go to KICK.
- **KICK**: `conv_start`=1 for this one cycle; go to WAIT_CONV.
- **WAIT_CONV**: on `conv_done`, go to POOL_KICK if the latched `pool_en`=1, else go to NEXT.
- **POOL_KICK**: `pool_start`=1 for this one cycle; go to WAIT_POOL.
- **WAIT_POOL**: on `pool_done`, go to NEXT.
- **NEXT**:
  - If `filter_idx` = `num_filters`−1, go to DONE.
  - Otherwise increment `filter_idx`, add `KERNEL_WORDS` to `w_addr_base`, add `FMAP_WORDS` to `out_addr_base`, and go to KICK.
- **DONE**: `layer_done`=1 for this one cycle; go to IDLE.
- Encoding of any unused state: go to IDLE.

Address arithmetic:
- Address updates are incremental adds (no multiplier).
- Results are unsigned and truncated to ADDR_W, so they wrap modulo 2^ADDR_W without any flag.
- Addresses and `filter_idx` hold their last values in IDLE until the next SETUP.

Boundary conditions:
- `start` outside IDLE is ignored; latched values do not change.
- `conv_done` in any state other than WAIT_CONV sets `err` and is otherwise ignored.
- `pool_done` in any state other than WAIT_POOL sets `err` and is otherwise ignored.
- This includes a done pulse that arrives in the same cycle as its own start pulse.
- `err` stays set until the next accepted `start` or `rst`.
- `conv_done` and `pool_done` arriving together in WAIT_CONV: `conv_done` is acted on and `pool_done` sets `err`.
- Asserting `rst` mid-layer forces IDLE and clears every output immediately. No `layer_done` is issued, and the engines are not notified.
- `num_filters` = 2^NF_W−1 runs all 15 filters; the counter does not overflow.

## Timing
- `start` sampled at edge t: `busy` rises after edge t, SETUP occupies cycle t+1, and `conv_start` is high in cycle t+2.
- `conv_done` sampled at edge u:
  - with `pool_en`=0: NEXT in cycle u+1 and the next `conv_start` in cycle u+2, so 2 cycles of overhead per filter;
  - with `pool_en`=1: `pool_start` in cycle u+1.
- `pool_done` sampled at edge v: NEXT in cycle v+1.
- After the last filter's NEXT, `layer_done` is high for one cycle and `busy` falls in the same cycle that `layer_done` falls.
- With `num_filters`=0: SETUP in cycle t+1, `layer_done` in cycle t+2, and no `conv_start` is issued.
- A new `start` is accepted in the first IDLE cycle after DONE.

## Test plan
- **Three filters, no pooling.** Stimulus: `num_filters`=3, `pool_en`=0, `w_base`=0x100, `out_base`=0x400, engine returns `conv_done` 5 cycles after each `conv_start`. Required: exactly 3 `conv_start` pulses, with `w_addr_base` = 0x100, 0x109, 0x112 and `out_addr_base` = 0x400, 0x6A4, 0x948; `filter_idx` = 0, 1, 2; one `layer_done`; `err`=0.
- **Two filters, pooling on.** Stimulus: `num_filters`=2, `pool_en`=1. Required: the pulse sequence is conv_start, conv_done, pool_start, pool_done, conv_start, conv_done, pool_start, pool_done, layer_done; each `pool_start` comes exactly 1 cycle after the `conv_done` edge.
- **Zero filters.** Stimulus: `num_filters`=0. Required: `layer_done` 2 cycles after `start`, no `conv_start` or `pool_start`, `busy` high for 2 cycles.
- **Protocol errors.** Stimulus: `conv_done` pulsed while the FSM is in WAIT_POOL, then a `start` pulsed while busy. Required: `err`=1 and the FSM stays in WAIT_POOL; the extra `start` has no effect; `err` clears on the next accepted `start`.
- **Wrap-around.** Stimulus: `out_base`=0xD00, `num_filters`=2. Required: `out_addr_base` for the second filter is 0xFA4; then `out_base`=0xFA0 gives 0x244 for the second filter (wrapped mod 4096).
- **Reset mid-layer.** Stimulus: assert `rst` in WAIT_CONV of filter 1 of 3. Required: all outputs are 0 in the same cycle and stay 0 while `rst` is high; after release the FSM is in IDLE and a new `start` runs normally from filter 0.
